// File: rtl/aspiradora_cmd_encoder_if.sv
// Switch-to-command bus: raw switches and enable in, debounced levels
// and accepted command (one-hot, code, valid/conflict pulses) out.
interface aspiradora_cmd_encoder_if;
  logic       ena;
  logic [3:0] sw_in;
  logic [3:0] sw_stable;
  logic [3:0] cmd_onehot;
  logic [1:0] cmd_code;
  logic       cmd_valid;
  logic       conflict;

  modport master (
    output ena,
    output sw_in,
    input  sw_stable,
    input  cmd_onehot,
    input  cmd_code,
    input  cmd_valid,
    input  conflict
  );

  modport slave (
    input  ena,
    input  sw_in,
    output sw_stable,
    output cmd_onehot,
    output cmd_code,
    output cmd_valid,
    output conflict
  );
endinterface

// File: rtl/aspiradora_cmd_encoder.sv
// Vacuum command encoder: sync + debounce 4 switches, pick one rising
// edge by priority. Ports: clk, rst_n (sync, active-low), bus (slave).
module aspiradora_cmd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  aspiradora_cmd_encoder_if.slave        bus
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [3:0]      stable_q;
  logic [3:0]      stable_d;
  logic [3:0]      prev_q;
  logic [3:0][7:0] cnt_q;
  logic [3:0][7:0] cnt_d;

  logic [3:0]      onehot_q;
  logic [3:0]      onehot_d;
  logic [1:0]      code_q;
  logic [1:0]      code_d;
  logic            valid_q;
  logic            valid_d;
  logic            conflict_q;
  logic            conflict_d;

  logic [3:0]      rise;
  logic [3:0]      edges;
  logic            multi;

  // Counter runs only while the synced level disagrees with the
  // stable one; reaching the limit commits the level and restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // power_off held high masks every other command edge.
  assign rise  = stable_q & ~prev_q;
  assign edges = {rise[3:1] & {3{~stable_q[0]}}, rise[0]};
  assign multi = (edges & (edges - 4'd1)) != 4'd0;

  always_comb begin
    onehot_d   = onehot_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    conflict_d = 1'b0;
    if (bus.ena && (edges != 4'd0)) begin
      valid_d    = 1'b1;
      conflict_d = multi;
      if (edges[0]) begin
        onehot_d = 4'b0001;
        code_d   = 2'd0;
      end else if (edges[3]) begin
        onehot_d = 4'b1000;
        code_d   = 2'd3;
      end else if (edges[2]) begin
        onehot_d = 4'b0100;
        code_d   = 2'd2;
      end else begin
        onehot_d = 4'b0010;
        code_d   = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      onehot_q   <= 4'b0001;
      code_q     <= 2'd0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= bus.sw_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      cnt_q      <= cnt_d;
      onehot_q   <= onehot_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.sw_stable  = stable_q;
  assign bus.cmd_onehot = onehot_q;
  assign bus.cmd_code   = code_q;
  assign bus.cmd_valid  = valid_q;
  assign bus.conflict   = conflict_q;

endmodule

// File: tb/tb_aspiradora_cmd_encoder.sv
// Directed bench for aspiradora_cmd_encoder with a command scoreboard.
// Expected commands are queued at stimulus time, popped on cmd_valid.
module tb_aspiradora_cmd_encoder;

  typedef struct {
    logic [1:0] code;
    logic [3:0] oh;
    logic       conf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got;

  aspiradora_cmd_encoder_if bus ();

  aspiradora_cmd_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] c, input logic [3:0] o,
                      input logic f);
    exp_t e;
    e.code = c;
    e.oh   = o;
    e.conf = f;
    sb.push_back(e);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("sb_code", 32'(bus.cmd_code), 32'(got.code));
        chk("sb_onehot", 32'(bus.cmd_onehot), 32'(got.oh));
        chk("sb_conflict", 32'(bus.conflict), 32'(got.conf));
      end
    end else if (bus.conflict !== 1'b0) begin
      chk("conflict_alone", 32'(bus.conflict), 32'd0);
    end
    if (rst_n && $countones(bus.cmd_onehot) != 1)
      chk("onehot_count", 32'($countones(bus.cmd_onehot)), 32'd1);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ena   = 1'b1;
    bus.sw_in = 4'b0000;
    rst_n     = 1'b0;
    tick(3);
    chk("rst_stable", 32'(bus.sw_stable), 32'h0);
    chk("rst_onehot", 32'(bus.cmd_onehot), 32'h1);
    chk("rst_code", 32'(bus.cmd_code), 32'h0);
    chk("rst_valid", 32'(bus.cmd_valid), 32'h0);
    chk("rst_conflict", 32'(bus.conflict), 32'h0);

    // on held: stable after edge 6, command after edge 7
    rst_n     = 1'b1;
    bus.sw_in = 4'b0010;
    tick(5);
    chk("lat_stable_e5", 32'(bus.sw_stable), 32'h0);
    tick(1);
    chk("lat_stable_e6", 32'(bus.sw_stable), 32'h2);
    chk("lat_valid_e6", 32'(bus.cmd_valid), 32'h0);
    push(2'd1, 4'b0010, 1'b0);
    tick(1);
    chk("lat_valid_e7", 32'(bus.cmd_valid), 32'h1);
    tick(1);
    chk("lat_valid_e8", 32'(bus.cmd_valid), 32'h0);

    // cleaning glitch of 3 cycles is filtered
    bus.sw_in = 4'b0110;
    tick(3);
    bus.sw_in = 4'b0010;
    tick(8);
    chk("glitch_stable", 32'(bus.sw_stable), 32'h2);
    chk("glitch_onehot", 32'(bus.cmd_onehot), 32'h2);

    // falling edges produce nothing, then cleaning+evading together
    bus.sw_in = 4'b0000;
    tick(8);
    chk("fall_stable", 32'(bus.sw_stable), 32'h0);
    bus.sw_in = 4'b1100;
    push(2'd3, 4'b1000, 1'b1);
    tick(8);
    chk("dual_stable", 32'(bus.sw_stable), 32'hc);
    chk("dual_code", 32'(bus.cmd_code), 32'h3);

    // power_off masks later on edge
    bus.sw_in = 4'b0000;
    tick(8);
    bus.sw_in = 4'b0001;
    push(2'd0, 4'b0001, 1'b0);
    tick(8);
    bus.sw_in = 4'b0011;
    tick(8);
    chk("mask_stable", 32'(bus.sw_stable), 32'h3);
    chk("mask_code", 32'(bus.cmd_code), 32'h0);
    bus.sw_in = 4'b0000;
    tick(8);
    bus.sw_in = 4'b0010;
    push(2'd1, 4'b0010, 1'b0);
    tick(8);
    chk("unmask_code", 32'(bus.cmd_code), 32'h1);

    // ena low discards evading edge, nothing queued
    bus.ena   = 1'b0;
    bus.sw_in = 4'b1010;
    tick(8);
    chk("ena_stable", 32'(bus.sw_stable), 32'ha);
    bus.ena = 1'b1;
    tick(8);
    chk("ena_onehot", 32'(bus.cmd_onehot), 32'h2);

    // re-accept held command
    bus.sw_in = 4'b0000;
    tick(8);
    bus.sw_in = 4'b0010;
    push(2'd1, 4'b0010, 1'b0);
    tick(8);
    chk("reacc_onehot", 32'(bus.cmd_onehot), 32'h2);

    // on+cleaning together: cleaning wins with conflict
    bus.sw_in = 4'b0000;
    tick(8);
    bus.sw_in = 4'b0110;
    push(2'd2, 4'b0100, 1'b1);
    tick(8);
    chk("prio_code", 32'(bus.cmd_code), 32'h2);

    // reset in mid-debounce of cleaning, held through release
    bus.sw_in = 4'b0000;
    tick(8);
    bus.sw_in = 4'b0100;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_stable", 32'(bus.sw_stable), 32'h0);
    chk("mid_rst_onehot", 32'(bus.cmd_onehot), 32'h1);
    chk("mid_rst_code", 32'(bus.cmd_code), 32'h0);
    rst_n = 1'b1;
    push(2'd2, 4'b0100, 1'b0);
    tick(6);
    chk("rel_valid_e6", 32'(bus.cmd_valid), 32'h0);
    tick(1);
    chk("rel_valid_e7", 32'(bus.cmd_valid), 32'h1);
    chk("rel_code_e7", 32'(bus.cmd_code), 32'h2);

    tick(10);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
